ex_mul_unit: RTL and testbench
==============================

Name: ex_mul_unit

Overview:
- Iterative multiplier in the EX stage, directly downstream of the decode-to-execute pipeline register.
- Consumes EX_mul, EX_a and EX_b from that register and returns the low XLEN bits of EX_a*EX_b.
- While a multiply is in progress it raises mul_stall. Pipeline control ORs mul_stall into the hold of the decode-to-execute register, so EX operands stay stable until the result is produced.

Parameters:
- XLEN, 32, operand and result width.
- BITS_PER_CYCLE, 2, multiplier bits retired per BUSY cycle; must divide XLEN (supported values 1, 2, 4).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- EX_mul  in  1  EX instruction is a multiply
- EX_a  in  XLEN  multiplicand
- EX_b  in  XLEN  multiplier
- MEM_stall  in  1  downstream hold; the pipeline does not advance this cycle
- flush  in  1  kill the in-flight EX instruction
- mul_stall  out  1  hold D/EX and upstream stages
- mul_busy  out  1  state is BUSY
- mul_valid  out  1  mul_result is valid for the current EX instruction
- mul_result  out  XLEN  low XLEN bits of the product

Behaviour:
- Reset is synchronous, active-high, on clk. Registered outputs after reset: state=IDLE, mul_valid=0, mul_result=0, mul_busy=0.
- mul_stall is forced to 0 while rst is high.
- Constant: N = XLEN/BITS_PER_CYCLE.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If EX_mul && !flush: mul_stall=1 (combinational), latch mcand=EX_a, mplier=EX_b, acc=0, cnt=0; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - mul_stall=1, mul_busy=1.
  - Each cycle: acc += (mcand * mplier[BITS_PER_CYCLE-1:0]) truncated to XLEN; mcand <<= BITS_PER_CYCLE; mplier >>= BITS_PER_CYCLE; cnt++.
  - When cnt reaches N-1, the update completes and the next state is DONE.
- DONE:
  - mul_valid=1, mul_result=acc, mul_stall=0.
  - If MEM_stall, stay in DONE with the result held.
  - Otherwise go to IDLE and drop mul_valid the next cycle.
- Latency (XLEN=32, BITS_PER_CYCLE=2):
  - mul_stall is high for 17 consecutive cycles (the IDLE accept cycle plus 16 BUSY cycles).
  - mul_valid rises the cycle after the last BUSY cycle.
- Arithmetic is unsigned and modulo 2^XLEN. The low half is identical for signed operands.
- All arithmetic is done in XLEN bits; overflow is discarded.
- Back-to-back multiplies:
  - The D/EX register advances in the DONE cycle and loads the next instruction.
  - The next cycle is IDLE; if EX_mul=1, a new multiply starts with no extra bubble.
  - The DONE-to-IDLE path never restarts the same instruction, because the stall has already released.
- flush, in any state: next state is IDLE and mul_valid=0. This cycle mul_stall=0. Flush takes priority over start and over a DONE hold.
- rst mid-operation: abort immediately to the reset state; no partial result is visible.
- Operand value zero (either operand) runs the full N BUSY cycles and gives result 0 (unless the early-out option below is compiled in).
- Operand changes on EX_a/EX_b while BUSY are ignored; the operands were latched at start.

Optional Feature:
- Macro: MUL_EARLY_OUT_EN.
- Defined:
  - In BUSY, if the post-shift mplier is 0, go to DONE next cycle regardless of cnt.
  - In IDLE, if EX_b==0, go straight to DONE with acc=0. Stall is then 1 cycle.
- Undefined: fixed N BUSY cycles, giving deterministic latency.
- The result value is identical in both builds.

Decomposition:
- Shared package pipe_pkg:
  - state encoding typedef mul_state_t (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - XLEN default
  - localparam MUL_ITERS = XLEN/BITS_PER_CYCLE
- One natural sub-module: mul_step, a combinational partial-product-and-accumulate for one BITS_PER_CYCLE slice, instantiated once.
- The FSM and registers stay in ex_mul_unit.

Test Plan:
- 7 * 6, EX_mul held 1, MEM_stall=0 -> mul_stall high exactly 17 cycles, then mul_valid=1, mul_result=42 for 1 cycle.
- 0xFFFFFFFF * 0xFFFFFFFF -> mul_result=0x00000001 (truncated).
- 0x80000000 * 2 -> mul_result=0.
- Result 42 in DONE with MEM_stall=1 for 3 cycles -> mul_valid and mul_result=42 held for 4 cycles; mul_stall=0 throughout.
- Two back-to-back multiplies 3*5 then 9*9 -> results 15 then 81; exactly one DONE cycle between the two stall windows; no duplicate start.
- flush asserted at BUSY cycle 5 -> next cycle IDLE, mul_valid never rises, mul_stall=0. rst at BUSY cycle 8 -> all outputs 0 the next cycle.
- With MUL_EARLY_OUT_EN: 5*3 -> stall 2 cycles, result 15; 123*0 -> stall 1 cycle, result 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: multiplier FSM encoding and default datapath sizing.
package pipe_pkg;

  localparam int XLEN_DEFAULT           = 32;
  localparam int BITS_PER_CYCLE_DEFAULT = 2;
  localparam int MUL_ITERS              = XLEN_DEFAULT / BITS_PER_CYCLE_DEFAULT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One radix-2^BITS_PER_CYCLE step of the iterative multiplier: acc + mcand * digit, modulo 2^XLEN.
module mul_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [XLEN-1:0]           mcand,
  input  logic [BITS_PER_CYCLE-1:0] digit,
  input  logic [XLEN-1:0]           acc,
  output logic [XLEN-1:0]           acc_next
);

  logic [XLEN-1:0] partial;

  // Shift-and-add keeps the partial product to a few small adders instead of a full multiplier.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (digit[i]) partial = partial + (mcand << i);
    end
  end

  assign acc_next = acc + partial;

endmodule

// File: rtl/ex_mul_unit.sv
// EX-stage iterative multiplier returning the low XLEN bits of EX_a*EX_b.
// Optional MUL_EARLY_OUT_EN: finish as soon as the remaining multiplier bits are zero.
module ex_mul_unit
  import pipe_pkg::*;
#(
  parameter int XLEN           = XLEN_DEFAULT,
  parameter int BITS_PER_CYCLE = BITS_PER_CYCLE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            EX_mul,
  input  logic [XLEN-1:0] EX_a,
  input  logic [XLEN-1:0] EX_b,
  input  logic            MEM_stall,
  input  logic            flush,
  output logic            mul_stall,
  output logic            mul_busy,
  output logic            mul_valid,
  output logic [XLEN-1:0] mul_result
);

  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS);

  mul_state_t      state;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] acc_next;
  logic [XLEN-1:0] mplier_shifted;
  logic            last_step;

  mul_step #(
    .XLEN          (XLEN),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_mul_step (
    .mcand   (mcand),
    .digit   (mplier[BITS_PER_CYCLE-1:0]),
    .acc     (acc),
    .acc_next(acc_next)
  );

  assign mplier_shifted = mplier >> BITS_PER_CYCLE;

`ifdef MUL_EARLY_OUT_EN
  assign last_step = (cnt == CNT_W'(ITERS - 1)) || (mplier_shifted == '0);
`else
  assign last_step = (cnt == CNT_W'(ITERS - 1));
`endif

  // Stall covers the accept cycle and every BUSY cycle so D/EX holds the operands stable.
  assign mul_stall = !rst && !flush && ((state == IDLE && EX_mul) || state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      mul_busy   <= 1'b0;
      mul_valid  <= 1'b0;
      mul_result <= '0;
    end else if (flush) begin
      state     <= IDLE;
      mul_busy  <= 1'b0;
      mul_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (EX_mul) begin
            mcand  <= EX_a;
            mplier <= EX_b;
            acc    <= '0;
            cnt    <= '0;
`ifdef MUL_EARLY_OUT_EN
            if (EX_b == '0) begin
              state      <= DONE;
              mul_busy   <= 1'b0;
              mul_valid  <= 1'b1;
              mul_result <= '0;
            end else begin
              state    <= BUSY;
              mul_busy <= 1'b1;
            end
`else
            state    <= BUSY;
            mul_busy <= 1'b1;
`endif
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier_shifted;
          cnt    <= cnt + 1'b1;
          if (last_step) begin
            state      <= DONE;
            mul_busy   <= 1'b0;
            mul_valid  <= 1'b1;
            mul_result <= acc_next;
          end
        end
        DONE: begin
          // Leaving DONE never restarts: D/EX already advanced while stall was low.
          if (!MEM_stall) begin
            state     <= IDLE;
            mul_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mul_busy  <= 1'b0;
          mul_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mul_unit.sv
// Scoreboard bench for ex_mul_unit: a D/EX register model drives operands, a monitor checks results and latency.
module tb_ex_mul_unit;

  localparam int XLEN = 32;
  localparam int BPC  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            EX_mul;
  logic [XLEN-1:0] EX_a;
  logic [XLEN-1:0] EX_b;
  logic            MEM_stall;
  logic            flush;
  logic            mul_stall;
  logic            mul_busy;
  logic            mul_valid;
  logic [XLEN-1:0] mul_result;

  typedef struct {
    logic [XLEN-1:0] result;
    int              stall_len;
    int              valid_len;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  ex_mul_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .EX_mul    (EX_mul),
    .EX_a      (EX_a),
    .EX_b      (EX_b),
    .MEM_stall (MEM_stall),
    .flush     (flush),
    .mul_stall (mul_stall),
    .mul_busy  (mul_busy),
    .mul_valid (mul_valid),
    .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Stall cycles are the accept cycle plus one per multiplier digit actually consumed.
  function automatic int expStall(input logic [XLEN-1:0] b);
`ifdef MUL_EARLY_OUT_EN
    int n = 0;
    logic [XLEN-1:0] r = b;
    while (r != 0) begin
      r = r >> BPC;
      n++;
    end
    return 1 + n;
`else
    return 1 + XLEN / BPC;
`endif
  endfunction

  // Presents one instruction in D/EX and holds it until the pipeline would advance.
  task automatic applyStimulus(input logic mul, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input int hold, input bit scramble);
    logic [63:0] prod;
    int held = 0;
    bit adv;
    EX_mul = mul;
    EX_a = a;
    EX_b = b;
    MEM_stall = 1'b0;
    if (mul) begin
      prod = 64'(a) * 64'(b);
      sb_q.push_back('{result: prod[XLEN-1:0], stall_len: expStall(b), valid_len: hold + 1});
    end
    for (int cyc = 0; ; cyc++) begin
      if (cyc >= 200) begin
        checkOutput("advance_timeout", 32'(cyc), 32'd0);
        break;
      end
      @(negedge clk);
      if (mul_valid && held < hold) begin
        MEM_stall = 1'b1;
        held++;
      end else begin
        MEM_stall = 1'b0;
      end
      adv = !mul_stall && !MEM_stall;
      @(posedge clk);
      #2;
      if (adv) break;
      if (scramble && mul_busy) begin
        EX_a = $urandom;
        EX_b = $urandom;
      end
    end
    MEM_stall = 1'b0;
  endtask

  // Kills a long multiply partway through BUSY with either flush or rst.
  task automatic abortTest(input bit use_rst, input int busy_cycle);
    EX_mul = 1'b1;
    EX_a = $urandom | 32'd1;
    EX_b = 32'hFFFF_FFFF;
    repeat (busy_cycle) @(posedge clk);
    #2;
    @(negedge clk);
    checkOutput(use_rst ? "rst_busy_before" : "flush_busy_before", 32'(mul_busy), 32'd1);
    @(posedge clk);
    #2;
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(negedge clk);
    checkOutput(use_rst ? "rst_stall" : "flush_stall", 32'(mul_stall), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    flush = 1'b0;
    EX_mul = 1'b0;
    @(negedge clk);
    checkOutput(use_rst ? "rst_after_busy" : "flush_after_busy", 32'(mul_busy), 32'd0);
    checkOutput(use_rst ? "rst_after_valid" : "flush_after_valid", 32'(mul_valid), 32'd0);
    checkOutput(use_rst ? "rst_after_stall" : "flush_after_stall", 32'(mul_stall), 32'd0);
    if (use_rst) checkOutput("rst_after_result", mul_result, 32'd0);
    repeat (20) @(posedge clk);
    #2;
  endtask

  // Monitor: pops the scoreboard on each rising mul_valid and checks value, latency and hold length.
  initial begin
    exp_t cur;
    bit   have_cur = 0;
    bit   prev_valid = 0;
    int   run = 0;
    int   vlen = 0;
    forever begin
      @(negedge clk);
      if (mul_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_valid", 32'(mul_valid), 32'd0);
          have_cur = 0;
        end else begin
          cur = sb_q.pop_front();
          have_cur = 1;
          vlen = 0;
          checkOutput("stall_len", 32'(run), 32'(cur.stall_len));
        end
      end
      if (mul_valid && have_cur) begin
        vlen++;
        checkOutput("result", mul_result, cur.result);
        checkOutput("stall_in_done", 32'(mul_stall), 32'd0);
      end
      if (!mul_valid && prev_valid && have_cur) begin
        checkOutput("valid_len", 32'(vlen), 32'(cur.valid_len));
        have_cur = 0;
      end
      if (mul_stall) run++;
      else run = 0;
      prev_valid = mul_valid;
    end
  end

  initial begin
    logic [XLEN-1:0] a, b;
    int kind;
    rst = 1'b1;
    EX_mul = 1'b1;
    EX_a = 32'd7;
    EX_b = 32'd6;
    flush = 1'b0;
    MEM_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_stall", 32'(mul_stall), 32'd0);
    checkOutput("reset_valid", 32'(mul_valid), 32'd0);
    checkOutput("reset_busy", 32'(mul_busy), 32'd0);
    checkOutput("reset_result", mul_result, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    EX_mul = 1'b0;
    @(negedge clk);
    checkOutput("idle_stall", 32'(mul_stall), 32'd0);
    @(posedge clk);
    #2;

    applyStimulus(1'b1, 32'd7, 32'd6, 0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 0, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    applyStimulus(1'b1, 32'h8000_0000, 32'd2, 0, 1'b0);
    applyStimulus(1'b1, 32'd6, 32'd7, 3, 1'b0);
    applyStimulus(1'b1, 32'd3, 32'd5, 0, 1'b0);
    applyStimulus(1'b1, 32'd9, 32'd9, 0, 1'b1);
    applyStimulus(1'b1, 32'd5, 32'd3, 0, 1'b0);
    applyStimulus(1'b1, 32'd123, 32'd0, 1, 1'b0);
    applyStimulus(1'b1, 32'd0, 32'd123, 0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 0, 1'b0);

    abortTest(1'b0, 5);
    abortTest(1'b1, 8);

    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      if (kind == 1) b = b & 32'h0000_00FF;
      if (kind == 2) b = 32'd0;
      if (kind == 3) a = 32'hFFFF_FFFF;
      applyStimulus(kind != 0, a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
